// File: rtl/epc_stack.sv
// epc_stack: LIFO of saved exception PCs/causes with registered redirect.
// Optional interrupt-enable tracking via `define EPC_STACK_IE_EN.
module epc_stack #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter int               CAUSE_W = 5,
    parameter logic [WIDTH-1:0] VECTOR  = 32'h0000_0080
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exc_req,
    input  logic [WIDTH-1:0]           exc_pc,
    input  logic                       exc_bd,
    input  logic [CAUSE_W-1:0]         exc_cause,
`ifdef EPC_STACK_IE_EN
    input  logic                       exc_async,
    output logic                       ie,
`endif
    input  logic                       eret,
    input  logic                       we,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           epc_out,
    output logic [CAUSE_W-1:0]         cause_out,
    output logic                       bd_out,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       redirect,
    output logic [WIDTH-1:0]           target,
    output logic                       ovf,
    output logic                       unf
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;

    logic [WIDTH-1:0]   pc_q    [DEPTH];
    logic [CAUSE_W-1:0] cause_q [DEPTH];
    logic               bd_q    [DEPTH];
    logic [LW-1:0]      level_q;

    logic               empty;
    logic               full;
    logic [IW-1:0]      top;
    logic [IW-1:0]      wr_idx;
    logic [WIDTH-1:0]   saved_pc;
    logic               acc;

`ifdef EPC_STACK_IE_EN
    logic               ie_q;
    logic               ie_ent [DEPTH];
    // Interrupts are masked while ie is clear; sync exceptions never are.
    assign acc = exc_req & ~(exc_async & ~ie_q);
    assign ie  = ie_q;
`else
    assign acc = exc_req;
`endif

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign top      = empty ? '0 : IW'(level_q - LW'(1));
    assign wr_idx   = level_q[IW-1:0];
    assign saved_pc = exc_bd ? (exc_pc - WIDTH'(4)) : exc_pc;

    assign epc_out   = pc_q[top];
    assign cause_out = cause_q[top];
    assign bd_out    = bd_q[top];
    assign level     = level_q;

    // Stack state, redirect pulse and sticky flags; priority is
    // exc+eret, exc, eret, then software write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                cause_q[i] <= '0;
                bd_q[i]    <= 1'b0;
`ifdef EPC_STACK_IE_EN
                ie_ent[i]  <= 1'b0;
`endif
            end
            level_q  <= '0;
            redirect <= 1'b0;
            target   <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
`ifdef EPC_STACK_IE_EN
            ie_q     <= 1'b1;
`endif
        end else begin
            redirect <= 1'b0;
            if (acc && eret) begin
                // Pop-then-push: top entry replaced, or a plain push when empty.
                pc_q[top]    <= saved_pc;
                cause_q[top] <= exc_cause;
                bd_q[top]    <= exc_bd;
                if (empty)
                    level_q <= level_q + LW'(1);
`ifdef EPC_STACK_IE_EN
                ie_ent[top] <= empty ? ie_q : ie_ent[top];
                ie_q        <= 1'b0;
`endif
                redirect <= 1'b1;
                target   <= VECTOR;
            end else if (acc) begin
                if (!full) begin
                    pc_q[wr_idx]    <= saved_pc;
                    cause_q[wr_idx] <= exc_cause;
                    bd_q[wr_idx]    <= exc_bd;
                    level_q         <= level_q + LW'(1);
`ifdef EPC_STACK_IE_EN
                    ie_ent[wr_idx]  <= ie_q;
                    ie_q            <= 1'b0;
`endif
                end else begin
                    ovf <= 1'b1;
                end
                // Double faults still go to the handler.
                redirect <= 1'b1;
                target   <= VECTOR;
            end else if (eret) begin
                if (!empty) begin
                    redirect <= 1'b1;
                    target   <= pc_q[top];
                    level_q  <= level_q - LW'(1);
`ifdef EPC_STACK_IE_EN
                    ie_q     <= ie_ent[top];
`endif
                end else begin
                    unf <= 1'b1;
                end
            end else if (we) begin
                pc_q[top] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_epc_stack.sv
// tb_epc_stack: directed stimulus with a redirect scoreboard
// and direct state checks.
module tb_epc_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc_req = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        exc_bd = 1'b0;
    logic [4:0]  exc_cause = '0;
    logic        eret = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] epc_out;
    logic [4:0]  cause_out;
    logic        bd_out;
    logic [2:0]  level;
    logic        redirect;
    logic [31:0] target;
    logic        ovf;
    logic        unf;
`ifdef EPC_STACK_IE_EN
    logic        exc_async = 1'b0;
    logic        ie;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    epc_stack dut (
        .clk       (clk),
        .rst       (rst),
        .exc_req   (exc_req),
        .exc_pc    (exc_pc),
        .exc_bd    (exc_bd),
        .exc_cause (exc_cause),
`ifdef EPC_STACK_IE_EN
        .exc_async (exc_async),
        .ie        (ie),
`endif
        .eret      (eret),
        .we        (we),
        .wdata     (wdata),
        .epc_out   (epc_out),
        .cause_out (cause_out),
        .bd_out    (bd_out),
        .level     (level),
        .redirect  (redirect),
        .target    (target),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (redirect === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_redirect: got target %0h expected none",
                         target);
            end else begin
                chk("redirect_target", target, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic e, input logic [31:0] pc,
                       input logic bd, input logic [4:0] c,
                       input logic er, input logic w,
                       input logic [31:0] wd, input logic r,
                       input logic rd, input logic [31:0] t);
        @(negedge clk);
        exc_req = e; exc_pc = pc; exc_bd = bd; exc_cause = c;
        eret = er; we = w; wdata = wd; rst = r;
        @(posedge clk);
        #1;
        if (rd) exp_q.push_back(t);
        exc_req = 1'b0; eret = 1'b0; we = 1'b0; rst = 1'b0;
`ifdef EPC_STACK_IE_EN
        exc_async = 1'b0;
`endif
    endtask

    task automatic push(input logic [31:0] pc, input logic bd,
                        input logic [4:0] c);
        cyc(1'b1, pc, bd, c, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h80);
    endtask

    task automatic pop(input logic rd, input logic [31:0] t);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, rd, t);
    endtask

    task automatic check_zero(input string n);
        chk({n, "_level"}, 32'(level), 0);
        chk({n, "_epc"}, epc_out, 0);
        chk({n, "_cause"}, 32'(cause_out), 0);
        chk({n, "_bd"}, 32'(bd_out), 0);
        chk({n, "_redirect"}, 32'(redirect), 0);
        chk({n, "_target"}, target, 0);
        chk({n, "_ovf"}, 32'(ovf), 0);
        chk({n, "_unf"}, 32'(unf), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs [5];
        pcs = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};

        // Reset state
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        check_zero("reset");

        // Plain push
        push(32'h1000, 1'b0, 5'd4);
        chk("p1_level", 32'(level), 1);
        chk("p1_epc", epc_out, 32'h1000);
        chk("p1_cause", 32'(cause_out), 4);
        chk("p1_bd", 32'(bd_out), 0);

        // Branch-delay push, then eret
        push(32'h2004, 1'b1, 5'd2);
        chk("bd_level", 32'(level), 2);
        chk("bd_epc", epc_out, 32'h2000);
        chk("bd_flag", 32'(bd_out), 1);
        pop(1'b1, 32'h2000);
        chk("bd_pop_level", 32'(level), 1);
        chk("bd_pop_epc", epc_out, 32'h1000);
        pop(1'b1, 32'h1000);
        chk("pop0_level", 32'(level), 0);

        // eret while empty
        pop(1'b0, '0);
        chk("unf_flag", 32'(unf), 1);
        chk("unf_level", 32'(level), 0);

        // Overflow run
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        chk("rst2_unf", 32'(unf), 0);
        for (int i = 0; i < 4; i++) push(pcs[i], 1'b0, 5'(i + 1));
        chk("full_ovf_clear", 32'(ovf), 0);
        push(pcs[4], 1'b0, 5'd5);
        chk("full_level", 32'(level), 4);
        chk("full_ovf", 32'(ovf), 1);
        chk("full_epc", epc_out, 32'h40);
        chk("full_cause", 32'(cause_out), 4);
        for (int i = 3; i >= 0; i--) pop(1'b1, pcs[i]);
        chk("drain_level", 32'(level), 0);
        chk("ovf_sticky", 32'(ovf), 1);

        // Software write of top entry
        push(32'h100, 1'b0, 5'd1);
        push(32'h200, 1'b0, 5'd2);
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b0, '0);
        chk("we_epc", epc_out, 32'h1234);
        chk("we_level", 32'(level), 2);
        pop(1'b1, 32'h1234);
        chk("we_below", epc_out, 32'h100);
        chk("we_below_cause", 32'(cause_out), 1);

        // Simultaneous exc+eret replaces top; we ignored
        push(32'h200, 1'b0, 5'd2);
        cyc(1'b1, 32'h300, 1'b0, 5'd7, 1'b1, 1'b1, 32'hdead, 1'b0,
            1'b1, 32'h80);
        chk("both_level", 32'(level), 2);
        chk("both_epc", epc_out, 32'h300);
        chk("both_cause", 32'(cause_out), 7);
        pop(1'b1, 32'h300);
        chk("both_below", epc_out, 32'h100);

        // Mid-sequence reset overrides a simultaneous exception
        cyc(1'b1, 32'h999, 1'b0, 5'd3, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        check_zero("midrst");

        // we at level 0 writes entry[0]
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'habc, 1'b0, 1'b0, '0);
        chk("we0_epc", epc_out, 32'habc);
        chk("we0_level", 32'(level), 0);

        // exc+eret at level 0 is a plain push
        cyc(1'b1, 32'h400, 1'b0, 5'd9, 1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h80);
        chk("both0_level", 32'(level), 1);
        chk("both0_epc", epc_out, 32'h400);
        chk("both0_unf", 32'(unf), 0);

`ifdef EPC_STACK_IE_EN
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        chk("ie_reset", 32'(ie), 1);
        push(32'h500, 1'b0, 5'd1);
        chk("ie_push", 32'(ie), 0);
        @(negedge clk);
        exc_req = 1'b1; exc_async = 1'b1; exc_pc = 32'h600;
        @(posedge clk);
        #1;
        exc_req = 1'b0; exc_async = 1'b0;
        chk("ie_mask_level", 32'(level), 1);
        chk("ie_mask_epc", epc_out, 32'h500);
        pop(1'b1, 32'h500);
        chk("ie_pop", 32'(ie), 1);
        @(negedge clk);
        exc_req = 1'b1; exc_async = 1'b1; exc_pc = 32'h700;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h80);
        exc_req = 1'b0; exc_async = 1'b0;
        chk("ie_async_level", 32'(level), 1);
        chk("ie_async_epc", epc_out, 32'h700);
        chk("ie_async_ie", 32'(ie), 0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pending_redirects", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/epc_stack.md
Name: epc_stack

Overview:
- Parametrised successor to the single-entry exception PC register in the MIPS CPU.
- Holds a LIFO of saved return PCs plus exception causes, so that nested exceptions and ERET work correctly.
- Produces a registered redirect (target PC plus pulse) that the PC-select logic consumes.
- Sits beside the CP0 logic in the EX/MEM stage.

Parameters:
- WIDTH, 32, PC/data width in bits.
- DEPTH, 4, number of stack entries (power of two, minimum 2).
- CAUSE_W, 5, width of the exception cause code.
- VECTOR, 32'h0000_0080, handler entry address driven on exception.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- exc_req  in  1  exception request, single-cycle pulse.
- exc_pc  in  WIDTH  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a branch delay slot.
- exc_cause  in  CAUSE_W  cause code.
- eret  in  1  return-from-exception request.
- we  in  1  software write of the top EPC (mtc0).
- wdata  in  WIDTH  write data for the top EPC.
- epc_out  out  WIDTH  top-of-stack saved PC.
- cause_out  out  CAUSE_W  top-of-stack cause.
- bd_out  out  1  top-of-stack branch-delay flag.
- level  out  $clog2(DEPTH)+1  current nesting depth.
- redirect  out  1  one-cycle pulse: load PC from target.
- target  out  WIDTH  redirect address.
- ovf  out  1  sticky: exception taken while the stack was full.
- unf  out  1  sticky: eret issued while the stack was empty.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - all entries 0, level=0, epc_out=0, cause_out=0, bd_out=0
  - redirect=0, target=0, ovf=0, unf=0
  - a reset asserted mid-operation overrides every other input in that cycle.
- Saved PC on push: exc_bd ? exc_pc-4 : exc_pc, computed mod 2^WIDTH.
- Per-cycle priority: simultaneous exc_req+eret, then exc_req, then eret, then we.
- Push (exc_req, level<DEPTH):
  - entry[level] <= {saved PC, exc_cause, exc_bd}; level <= level+1.
  - next cycle: redirect=1, target=VECTOR.
- Push when full (level==DEPTH):
  - no entry or level change; ovf <= 1.
  - redirect=1 with target=VECTOR still issued (double-fault handler).
- Pop (eret, level>0):
  - next cycle: redirect=1, target=old top saved PC.
  - level <= level-1.
- Pop when empty (level==0):
  - no redirect, no state change; unf <= 1.
- exc_req and eret in the same cycle:
  - treated as pop-then-push, i.e. the top entry is replaced by the new exception.
  - level unchanged; if level==0 this is a plain push (unf not set).
  - redirect to VECTOR.
- we alone: overwrites the top entry's PC with wdata; at level==0 it writes entry[0] without changing level.
- we is ignored in any cycle with exc_req or eret.
- Output timing:
  - epc_out, cause_out and bd_out are combinational reads of entry[level-1], or entry[0] when level==0.
  - they therefore reflect a push/pop/write from the cycle after it.
- redirect is high for exactly one cycle per accepted event; target holds its last value otherwise.
- ovf and unf clear only on rst.

Optional Feature:
- Macro: EPC_STACK_IE_EN.
- Defined:
  - adds input exc_async (1 = interrupt) and output ie (reset 1).
  - each entry additionally stores the ie bit at push time; on push, ie <= 0; on pop, ie <= the stored bit.
  - exc_req with exc_async=1 while ie=0 is ignored entirely (no push, no redirect, no flags).
  - exc_async=0 exceptions are never masked.
- Undefined: no ie state; ports exc_async and ie are absent; all exc_req are accepted.

Test Plan:
- rst, then exc_req with exc_pc=0x0000_1000, exc_bd=0, cause=4 -> next cycle redirect=1, target=0x80; then level=1, epc_out=0x1000, cause_out=4.
- Same push with exc_bd=1, exc_pc=0x2004 -> epc_out=0x2000, bd_out=1; a following eret -> redirect=1, target=0x2000, level=0.
- Five pushes with DEPTH=4 (PCs 0x10,0x20,0x30,0x40,0x50) -> level=4, ovf=1, epc_out=0x40, fifth redirect still target=0x80; four erets -> targets 0x40,0x30,0x20,0x10.
- eret at level=0 -> no redirect, unf=1, level=0; we=1 with wdata=0x1234 at level=2 -> epc_out=0x1234, entry below unchanged.
- exc_req(pc=0x300)+eret same cycle at level=2 -> level=2, epc_out=0x300, target=0x80; synchronous rst mid-sequence -> all outputs 0 next cycle.
- EPC_STACK_IE_EN: push sync exc -> ie=0; async exc_req -> ignored; eret -> ie=1; async exc_req -> accepted.
